// File: rtl/roundrobin_dispatcher_reg.sv
`default_nettype none
// ============================================================================
// Module   : roundrobin_dispatcher_reg
// Purpose  : Spreads one request stream over NUM_OUTPUT_PORT registered
//            one-entry slots in round-robin order, skipping busy ports.
// Revision : 1.0 - initial release
// ============================================================================
module roundrobin_dispatcher_reg #(
    parameter int  NUM_OUTPUT_PORT = 2,
    parameter int  PTR_W           = (NUM_OUTPUT_PORT > 1) ? $clog2(NUM_OUTPUT_PORT) : 1,
    parameter type mem_request_t   = logic [63:0]
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  mem_request_t                          in_request,
    output logic         [NUM_OUTPUT_PORT-1:0]    out_valid,
    input  logic         [NUM_OUTPUT_PORT-1:0]    out_ready,
    output mem_request_t [NUM_OUTPUT_PORT-1:0]    out_request,
    output logic         [PTR_W-1:0]              rr_ptr,
    output logic         [31:0]                   dispatch_count
);

    localparam int c_LAST_PORT = NUM_OUTPUT_PORT - 1;

    logic         [NUM_OUTPUT_PORT-1:0] r_out_valid;
    mem_request_t [NUM_OUTPUT_PORT-1:0] r_out_request;
    logic         [PTR_W-1:0]           r_rr_ptr;
    logic         [31:0]                r_dispatch_count;

    logic [NUM_OUTPUT_PORT-1:0] w_free;
    logic [NUM_OUTPUT_PORT-1:0] w_sel;
    logic [PTR_W-1:0]           w_hi_idx;
    logic [PTR_W-1:0]           w_lo_idx;
    logic [PTR_W-1:0]           w_sel_idx;
    logic [PTR_W-1:0]           w_ptr_next;
    logic                       w_hi_found;
    logic                       w_fire;

    // A slot draining this cycle can be reloaded in the same cycle.
    assign w_free   = ~r_out_valid | out_ready;
    assign in_ready = |w_free;
    assign w_fire   = in_valid & in_ready;

    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_sel      = '0;
        // Descending scan leaves the lowest qualifying index in each candidate.
        for (int i = c_LAST_PORT; i >= 0; i--) begin
            if (w_free[i]) begin
                w_lo_idx = PTR_W'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_hi_idx   = PTR_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_sel_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
            w_sel[i] = (int'(w_sel_idx) == i);
        end
        w_ptr_next = (int'(w_sel_idx) == c_LAST_PORT) ? '0 : (w_sel_idx + PTR_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= '0;
            r_out_request    <= '0;
            r_rr_ptr         <= '0;
            r_dispatch_count <= '0;
        end else begin
            for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
                if (w_fire && w_sel[i]) begin
                    r_out_valid[i]   <= 1'b1;
                    r_out_request[i] <= in_request;
                end else if (out_ready[i]) begin
                    r_out_valid[i]   <= 1'b0;
                end
            end
            if (w_fire) begin
                r_rr_ptr         <= w_ptr_next;
                r_dispatch_count <= r_dispatch_count + 32'd1;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_request    = r_out_request;
    assign rr_ptr         = r_rr_ptr;
    assign dispatch_count = r_dispatch_count;

endmodule
`default_nettype wire

// File: tb/tb_roundrobin_dispatcher_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_roundrobin_dispatcher_reg
// Purpose  : Directed bench for roundrobin_dispatcher_reg (N=4 and N=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_roundrobin_dispatcher_reg;

    typedef logic [15:0] req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst4, in_valid4, in_ready4;
    req_t             in_req4;
    logic [3:0]       out_valid4, out_ready4;
    req_t [3:0]       out_req4;
    logic [1:0]       rr4;
    logic [31:0]      cnt4;

    logic             rst1, in_valid1, in_ready1;
    req_t             in_req1;
    logic [0:0]       out_valid1, out_ready1;
    req_t [0:0]       out_req1;
    logic [0:0]       rr1;
    logic [31:0]      cnt1;

    int n_checks;
    int n_fail;

    roundrobin_dispatcher_reg #(
        .NUM_OUTPUT_PORT (4),
        .mem_request_t   (req_t)
    ) u_dut4 (
        .clk            (clk),
        .reset          (rst4),
        .in_valid       (in_valid4),
        .in_ready       (in_ready4),
        .in_request     (in_req4),
        .out_valid      (out_valid4),
        .out_ready      (out_ready4),
        .out_request    (out_req4),
        .rr_ptr         (rr4),
        .dispatch_count (cnt4)
    );

    roundrobin_dispatcher_reg #(
        .NUM_OUTPUT_PORT (1),
        .mem_request_t   (req_t)
    ) u_dut1 (
        .clk            (clk),
        .reset          (rst1),
        .in_valid       (in_valid1),
        .in_ready       (in_ready1),
        .in_request     (in_req1),
        .out_valid      (out_valid1),
        .out_ready      (out_ready1),
        .out_request    (out_req1),
        .rr_ptr         (rr1),
        .dispatch_count (cnt1)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input req_t v);
        in_valid4 = 1'b1;
        in_req4   = v;
        #1;
        check("send_in_ready", in_ready4, 1);
        tick();
        in_valid4 = 1'b0;
    endtask

    req_t q[$];
    int   sent;
    int   got;
    req_t nxt;
    logic exp_rdy;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst4 = 1'b1; in_valid4 = 1'b0; in_req4 = '0; out_ready4 = '0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_req1 = '0; out_ready1 = '0;
        tick();
        tick();
        rst4 = 1'b0;
        rst1 = 1'b0;
        #1;

        // Reset state
        check("rst_valid", out_valid4, 0);
        check("rst_req", out_req4, 0);
        check("rst_ptr", rr4, 0);
        check("rst_cnt", cnt4, 0);
        check("rst_in_ready", in_ready4, 1);

        // Full stream, all consumers ready
        out_ready4 = 4'hF;
        for (int k = 0; k < 8; k++) begin
            in_valid4 = 1'b1;
            in_req4   = req_t'(16'h00A0 + k);
            #1;
            check("s1_in_ready", in_ready4, 1);
            tick();
            check("s1_valid", out_valid4[k % 4], 1);
            check("s1_req", out_req4[k % 4], 16'h00A0 + k);
            check("s1_ptr", rr4, (k + 1) % 4);
        end
        in_valid4 = 1'b0;
        check("s1_cnt", cnt4, 8);
        check("s1_ptr_end", rr4, 0);

        // Skip a blocked preferred port
        out_ready4 = 4'b1101;
        tick();
        check("s2_drained", out_valid4, 0);
        send4(16'h0100);
        send4(16'h0111);
        send4(16'h0102);
        send4(16'h0103);
        send4(16'h0104);
        check("s2_pre_ptr", rr4, 1);
        check("s2_pre_valid", out_valid4, 4'b0011);
        send4(16'h0B00);
        check("s2_b_valid", out_valid4[2], 1);
        check("s2_b_req", out_req4[2], 16'h0B00);
        check("s2_ptr", rr4, 3);
        check("s2_p1_held", out_req4[1], 16'h0111);
        check("s2_p1_valid", out_valid4[1], 1);

        // Wrap-around when ports 3 and 0 are stalled
        out_ready4 = 4'b0110;
        send4(16'h0D03);
        check("s3_d3", out_req4[3], 16'h0D03);
        send4(16'h0D00);
        send4(16'h0D01);
        send4(16'h0D02);
        tick();
        check("s3_pre_valid", out_valid4, 4'b1001);
        check("s3_pre_ptr", rr4, 3);
        send4(16'h0C00);
        check("s3_c_valid", out_valid4[1], 1);
        check("s3_c_req", out_req4[1], 16'h0C00);
        check("s3_ptr", rr4, 2);
        check("s3_p3_held", out_req4[3], 16'h0D03);
        check("s3_p0_held", out_req4[0], 16'h0D00);
        check("s3_cnt", cnt4, 19);

        // Total back-pressure, then one port opens
        out_ready4 = 4'b0000;
        send4(16'h0E02);
        check("s4_full", out_valid4, 4'hF);
        in_valid4 = 1'b1;
        in_req4   = 16'h0F02;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("s4_in_ready", in_ready4, 0);
            tick();
            check("s4_p2_stable", out_req4[2], 16'h0E02);
            check("s4_p1_stable", out_req4[1], 16'h0C00);
            check("s4_valid", out_valid4, 4'hF);
        end
        check("s4_cnt_hold", cnt4, 20);
        check("s4_ptr_hold", rr4, 3);
        out_ready4 = 4'b0100;
        #1;
        check("s4_open_ready", in_ready4, 1);
        tick();
        in_valid4  = 1'b0;
        out_ready4 = 4'b0000;
        check("s4_p2_valid", out_valid4[2], 1);
        check("s4_p2_req", out_req4[2], 16'h0F02);
        check("s4_ptr", rr4, 3);
        check("s4_cnt", cnt4, 21);

        // Reset in the middle of traffic
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        out_ready4 = 4'hF;
        send4(16'h5000);
        send4(16'h5001);
        out_ready4 = 4'b0010;
        send4(16'h5002);
        send4(16'h5003);
        send4(16'h5004);
        check("s5_pre_valid", out_valid4, 4'b1101);
        check("s5_pre_cnt", cnt4, 5);
        in_valid4 = 1'b1;
        in_req4   = 16'h6000;
        rst4      = 1'b1;
        tick();
        rst4      = 1'b0;
        in_valid4 = 1'b0;
        check("s5_valid", out_valid4, 0);
        check("s5_ptr", rr4, 0);
        check("s5_cnt", cnt4, 0);
        check("s5_req", out_req4, 0);
        tick();
        check("s5_no_dispatch", out_valid4, 0);
        check("s5_cnt_after", cnt4, 0);

        // Single-port instance: alternating consumer readiness
        sent = 0;
        got  = 0;
        nxt  = 16'h1000;
        for (int c = 0; c < 12; c++) begin
            out_ready1[0] = (c % 2 == 1);
            in_valid1     = 1'b1;
            in_req1       = nxt;
            #1;
            check("n1_valid", out_valid1, (q.size() != 0));
            exp_rdy = (q.size() == 0) || out_ready1[0];
            check("n1_in_ready", in_ready1, exp_rdy);
            if (q.size() != 0 && out_ready1[0]) begin
                check("n1_data", out_req1[0], q.pop_front());
                got++;
            end
            if (exp_rdy) begin
                q.push_back(nxt);
                nxt++;
                sent++;
            end
            tick();
        end
        in_valid1     = 1'b0;
        out_ready1[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (q.size() != 0) begin
                check("n1_drain_data", out_req1[0], q.pop_front());
                got++;
            end
            tick();
        end
        check("n1_empty", out_valid1, 0);
        check("n1_count", cnt1, sent);
        check("n1_all_out", got, sent);
        check("n1_ptr", rr1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
